exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle execute controller that sequences one decoded R/I-type ALU operation at a time through the registered-read register file and the registered ALU: operand read, execute, write-back. Sits between the instruction decoders and the `reg_file`/`alu` pair and owns every control input of both. Also patches the ALU's zero-`value2` behaviour, where the ALU holds its stale result, with architecturally correct results.

## Interface
Parameters:
- `XLEN`, 64: datapath width.
- `IMM_W`, 12: immediate width; sign-extended to `XLEN`.

Ports:
- Clock and reset: one clock, `clk`; reset is `reset`, synchronous and active-high.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  decoded operation offered.
- `req_ready`  out  1  sequencer accepts this cycle.
- `req_op`  in  8  ALU op code (ADD=0, SUB=1, MUL=2, DIV=3, XOR=4, AND=5, OR=6, REM=7, NOT=8).
- `req_rs1`, `req_rs2`, `req_rd`  in  5 each  register indices.
- `req_use_imm`  in  1  operand 2 is the immediate, not `rs2`.
- `req_imm`  in  `IMM_W`  immediate.
- `rf_rs1`, `rf_rs2`  out  5 each  register-file read addresses.
- `rf_rs1_val`, `rf_rs2_val`  in  `XLEN`  register-file read data, valid one cycle after address.
- `rf_write_sig`  out  1  register-file write enable.
- `rf_write_reg`  out  5  write index.
- `rf_write_val`  out  `XLEN`  write data.
- `alu_opcode`  out  8  ALU op.
- `alu_value1`, `alu_value2`  out  `XLEN`  ALU operands.
- `alu_result`  in  `XLEN`  ALU result, registered inside the ALU.
- `done_valid`  out  1  one-cycle pulse on write-back.
- `done_rd`  out  5  destination of the completed op.
- `done_value`  out  `XLEN`  value written.
- `done_error`  out  1  divide-by-zero trap; exists only with `EXEC_DIV0_TRAP_EN`.

## Operation
- FSM states: `IDLE`, `READ`, `EXEC`, `WB`.
  - `IDLE -> READ` on `req_valid && req_ready`.
  - `READ -> EXEC` unconditionally.
  - `EXEC -> WB` unconditionally.
  - `WB -> IDLE` unconditionally.
- `req_ready` = 1 only in `IDLE`. The request is latched on handshake; `req_*` is ignored in every other state.
- `READ`: drive `rf_rs1`/`rf_rs2` from the latched indices.
- `EXEC`:
  - `alu_value1 = rf_rs1_val`.
  - `alu_value2 = req_use_imm ? sext(imm) : rf_rs2_val`.
  - `alu_opcode` = latched op.
  - Both operands are also captured internally.
- `WB` result selection:
  - If the captured `value2 != 0`, the result is `alu_result`.
  - Otherwise the sequencer substitutes: ADD/SUB/XOR/OR -> `value1`; AND/MUL -> 0; NOT -> `~value1`; DIV -> all ones; REM -> `value1`.
- `WB` outputs:
  - `done_valid` = 1 with `done_rd` and `done_value`.
  - `rf_write_sig` = 1 unless `rd == 0` or a trap occurred.
  - `rf_write_reg` = rd and `rf_write_val` = result.
- An unknown op (>8) completes normally with result 0 and no write.
- Outside their active states, `rf_*` and `alu_*` outputs are driven to 0.

## Timing
- Handshake at cycle N. `READ` = N+1, `EXEC` = N+2, `WB` = N+3 (write and `done_valid` in the same cycle). `req_ready` rises again at N+4.
- Throughput: one op per 4 cycles.
- Reset values:
  - `req_ready` = 1.
  - `rf_rs1`, `rf_rs2`, `rf_write_sig`, `rf_write_reg`, `rf_write_val` = 0.
  - `alu_opcode`, `alu_value1`, `alu_value2` = 0.
  - `done_valid`, `done_rd`, `done_value`, `done_error` = 0.
  - State = `IDLE`.
- Reset in any state aborts the op: no write, no `done_valid`, `IDLE` on the next cycle.
- `req_valid` asserted during busy states is ignored. The requester must hold it until it sees `req_ready`.
- Reading and writing the same register across back-to-back ops is safe. The write at N+3 precedes the next `READ` at N+5 or later.

## Configuration
- `EXEC_DIV0_TRAP_EN` defined:
  - DIV/REM with zero divisor asserts `done_error` = 1 in `WB`.
  - `rf_write_sig` = 0 for that op, `done_value` = 0.
- Not defined:
  - The `done_error` port is absent.
  - DIV/REM by zero writes the RISC-V results (all ones / dividend).

## Structure
- Package `exec_pkg`:
  - FSM state enum.
  - ALU op constants ADD..NOT.
  - `sext_imm` function.
- Sub-module `exec_zero_fixup`: combinational; inputs op, value1, value2 == 0, alu_result; outputs the final result and the trap flag.

## Test plan
- ADD x3 = x1 (5) + x2 (7) -> at N+3: `rf_write_sig`=1, reg 3, value 12, `done_valid` 1-cycle pulse.
- ADDI rd=4, rs1=x1 (5), imm=0xFFF -> value 4 (sign-extended -1).
- ADD x5 = x1 (9) + x0 -> value 9 (zero fix-up, not the stale ALU result).
- DIV x6 = x1 / x0:
  - Without the macro: writes 0xFFFF_FFFF_FFFF_FFFF.
  - With `EXEC_DIV0_TRAP_EN`: `done_error`=1, no write.
- Op with rd=0 -> `done_valid`=1, `rf_write_sig`=0.
- `reset` asserted in `EXEC` -> no write, `IDLE`/`req_ready`=1 next cycle; `req_valid` held during `READ` is not re-accepted until N+4.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared types, ALU op codes and the immediate sign-extension helper
// for the execute sequencer.
package exec_pkg;

  // Sequencer states: operand read, execute, write-back
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // ALU op codes understood by the downstream ALU
  localparam logic [7:0] OP_ADD = 8'd0;
  localparam logic [7:0] OP_SUB = 8'd1;
  localparam logic [7:0] OP_MUL = 8'd2;
  localparam logic [7:0] OP_DIV = 8'd3;
  localparam logic [7:0] OP_XOR = 8'd4;
  localparam logic [7:0] OP_AND = 8'd5;
  localparam logic [7:0] OP_OR  = 8'd6;
  localparam logic [7:0] OP_REM = 8'd7;
  localparam logic [7:0] OP_NOT = 8'd8;

  // Widest datapath the extension helper handles; callers cast to their XLEN
  localparam int SEXT_W = 64;

  // Sign-extend the low imm_w bits of imm to SEXT_W bits
  function automatic logic [SEXT_W-1:0] sext_imm(input logic [SEXT_W-1:0] imm,
                                                 input int imm_w);
    logic [SEXT_W-1:0] mask;
    logic [SEXT_W-1:0] bit_sel;
    logic              sign;
    mask    = ~({SEXT_W{1'b1}} << imm_w);
    bit_sel = (imm >> (imm_w - 1)) & {{(SEXT_W-1){1'b0}}, 1'b1};
    sign    = |bit_sel;
    return sign ? (imm | ~mask) : (imm & mask);
  endfunction

endpackage

// File: rtl/exec_zero_fixup.sv
// exec_zero_fixup: picks the architecturally correct result. When the second
// operand was zero the ALU holds a stale result, so a substitute is produced.
// Optional macro EXEC_DIV0_TRAP_EN adds the divide-by-zero trap output.
module exec_zero_fixup
  import exec_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [7:0]      op,
  input  logic [XLEN-1:0] value1,
  input  logic            value2_zero,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] result
`ifdef EXEC_DIV0_TRAP_EN
  ,
  output logic            trap
`endif
);

  // Result selection: live ALU result, or zero-operand substitute, or 0 for unknown ops
  always_comb begin
    result = {XLEN{1'b0}};
    if (op > OP_NOT) begin
      result = {XLEN{1'b0}};
    end else if (!value2_zero) begin
      result = alu_result;
    end else begin
      case (op)
        OP_ADD, OP_SUB, OP_XOR, OP_OR: result = value1;
        OP_AND, OP_MUL:                result = {XLEN{1'b0}};
        OP_NOT:                        result = ~value1;
        OP_DIV:                        result = {XLEN{1'b1}};
        OP_REM:                        result = value1;
        default:                       result = {XLEN{1'b0}};
      endcase
    end
  end

`ifdef EXEC_DIV0_TRAP_EN
  // Divide or remainder by zero raises the trap
  always_comb begin
    trap = 1'b0;
    if (value2_zero && ((op == OP_DIV) || (op == OP_REM))) begin
      trap = 1'b1;
    end else begin
      trap = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: four-state (IDLE/READ/EXEC/WB) controller driving a
// registered-read register file and a registered ALU for one op at a time.
// Optional macro EXEC_DIV0_TRAP_EN: DIV/REM by zero trap via done_error.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int IMM_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [7:0]       req_op,
  input  logic [4:0]       req_rs1,
  input  logic [4:0]       req_rs2,
  input  logic [4:0]       req_rd,
  input  logic             req_use_imm,
  input  logic [IMM_W-1:0] req_imm,
  output logic [4:0]       rf_rs1,
  output logic [4:0]       rf_rs2,
  input  logic [XLEN-1:0]  rf_rs1_val,
  input  logic [XLEN-1:0]  rf_rs2_val,
  output logic             rf_write_sig,
  output logic [4:0]       rf_write_reg,
  output logic [XLEN-1:0]  rf_write_val,
  output logic [7:0]       alu_opcode,
  output logic [XLEN-1:0]  alu_value1,
  output logic [XLEN-1:0]  alu_value2,
  input  logic [XLEN-1:0]  alu_result,
  output logic             done_valid,
  output logic [4:0]       done_rd,
  output logic [XLEN-1:0]  done_value
`ifdef EXEC_DIV0_TRAP_EN
  ,
  output logic             done_error
`endif
);

  state_t            state_r;
  logic [7:0]        op_r;
  logic [4:0]        rd_r;
  logic              use_imm_r;
  logic [IMM_W-1:0]  imm_r;
  logic [XLEN-1:0]   value1_r;
  logic              value2_zero_r;

  logic [XLEN-1:0]   imm_ext_s;
  logic [XLEN-1:0]   value2_s;
  logic              write_ok_s;
  logic [XLEN-1:0]   result_s;
  logic              trap_s;

  assign imm_ext_s = XLEN'(sext_imm(SEXT_W'(imm_r), IMM_W));
  assign value2_s  = use_imm_r ? imm_ext_s : rf_rs2_val;

  // Write permission decided in EXEC from live operands so rf_write_sig can be registered
  always_comb begin
    write_ok_s = 1'b0;
    if ((rd_r != 5'd0) && (op_r <= OP_NOT)) begin
`ifdef EXEC_DIV0_TRAP_EN
      write_ok_s = !((value2_s == {XLEN{1'b0}}) && ((op_r == OP_DIV) || (op_r == OP_REM)));
`else
      write_ok_s = 1'b1;
`endif
    end else begin
      write_ok_s = 1'b0;
    end
  end

  exec_zero_fixup #(.XLEN(XLEN)) u_fixup (
    .op          (op_r),
    .value1      (value1_r),
    .value2_zero (value2_zero_r),
    .alu_result  (alu_result),
    .result      (result_s)
`ifdef EXEC_DIV0_TRAP_EN
    ,
    .trap        (trap_s)
`endif
  );

`ifndef EXEC_DIV0_TRAP_EN
  assign trap_s = 1'b0;
`endif

  // FSM plus registered control outputs; request fields latched on handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      req_ready     <= 1'b1;
      op_r          <= 8'd0;
      rd_r          <= 5'd0;
      use_imm_r     <= 1'b0;
      imm_r         <= {IMM_W{1'b0}};
      value1_r      <= {XLEN{1'b0}};
      value2_zero_r <= 1'b0;
      rf_rs1        <= 5'd0;
      rf_rs2        <= 5'd0;
      alu_opcode    <= 8'd0;
      rf_write_sig  <= 1'b0;
      rf_write_reg  <= 5'd0;
      done_valid    <= 1'b0;
      done_rd       <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            state_r   <= ST_READ;
            req_ready <= 1'b0;
            op_r      <= req_op;
            rd_r      <= req_rd;
            use_imm_r <= req_use_imm;
            imm_r     <= req_imm;
            rf_rs1    <= req_rs1;
            rf_rs2    <= req_rs2;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_READ: begin
          state_r    <= ST_EXEC;
          rf_rs1     <= 5'd0;
          rf_rs2     <= 5'd0;
          alu_opcode <= op_r;
        end
        ST_EXEC: begin
          state_r       <= ST_WB;
          alu_opcode    <= 8'd0;
          value1_r      <= rf_rs1_val;
          value2_zero_r <= (value2_s == {XLEN{1'b0}});
          rf_write_sig  <= write_ok_s;
          rf_write_reg  <= rd_r;
          done_valid    <= 1'b1;
          done_rd       <= rd_r;
        end
        ST_WB: begin
          state_r      <= ST_IDLE;
          req_ready    <= 1'b1;
          rf_write_sig <= 1'b0;
          rf_write_reg <= 5'd0;
          done_valid   <= 1'b0;
          done_rd      <= 5'd0;
        end
        default: begin
          state_r   <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

  // ALU operands come straight from the register file read data during EXEC
  always_comb begin
    alu_value1 = {XLEN{1'b0}};
    alu_value2 = {XLEN{1'b0}};
    if (state_r == ST_EXEC) begin
      alu_value1 = rf_rs1_val;
      alu_value2 = value2_s;
    end else begin
      alu_value1 = {XLEN{1'b0}};
      alu_value2 = {XLEN{1'b0}};
    end
  end

  // Write-back data needs the ALU result that only becomes valid in WB
  always_comb begin
    rf_write_val = {XLEN{1'b0}};
    done_value   = {XLEN{1'b0}};
    if (state_r == ST_WB) begin
      rf_write_val = result_s;
      done_value   = trap_s ? {XLEN{1'b0}} : result_s;
    end else begin
      rf_write_val = {XLEN{1'b0}};
      done_value   = {XLEN{1'b0}};
    end
  end

`ifdef EXEC_DIV0_TRAP_EN
  // Trap flag is only meaningful alongside done_valid
  always_comb begin
    done_error = 1'b0;
    if (state_r == ST_WB) begin
      done_error = trap_s;
    end else begin
      done_error = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed checks of exec_sequencer against a small
// register-file and stale-holding ALU model.
module tb_exec_sequencer;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_op;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic        req_use_imm;
  logic [11:0] req_imm;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [63:0] rf_rs1_val, rf_rs2_val;
  logic        rf_write_sig;
  logic [4:0]  rf_write_reg;
  logic [63:0] rf_write_val;
  logic [7:0]  alu_opcode;
  logic [63:0] alu_value1, alu_value2;
  logic [63:0] alu_result = 64'd0;
  logic        done_valid;
  logic [4:0]  done_rd;
  logic [63:0] done_value;
  logic        done_error;

  int tests = 0;
  int fails = 0;

  logic        pre_we = 1'b0;
  logic [4:0]  pre_idx = 5'd0;
  logic [63:0] pre_val = 64'd0;
  logic        rf_clr = 1'b0;
  logic [63:0] regs [32];

  always #5 clk = ~clk;

  exec_sequencer #(.XLEN(64), .IMM_W(12)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .req_use_imm(req_use_imm), .req_imm(req_imm),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_val(rf_rs1_val), .rf_rs2_val(rf_rs2_val),
    .rf_write_sig(rf_write_sig), .rf_write_reg(rf_write_reg), .rf_write_val(rf_write_val),
    .alu_opcode(alu_opcode), .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_result(alu_result),
    .done_valid(done_valid), .done_rd(done_rd), .done_value(done_value)
`ifdef EXEC_DIV0_TRAP_EN
    , .done_error(done_error)
`endif
  );

`ifndef EXEC_DIV0_TRAP_EN
  assign done_error = 1'b0;
`endif

  // Register file model: registered read, x0 hard-wired to zero
  always @(posedge clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) regs[i] <= 64'd0;
    end else if (pre_we) begin
      regs[pre_idx] <= pre_val;
    end else if (rf_write_sig && (rf_write_reg != 5'd0)) begin
      regs[rf_write_reg] <= rf_write_val;
    end
    rf_rs1_val <= (rf_rs1 == 5'd0) ? 64'd0 : regs[rf_rs1];
    rf_rs2_val <= (rf_rs2 == 5'd0) ? 64'd0 : regs[rf_rs2];
  end

  // ALU model: registered result, holds stale value when operand 2 is zero
  always @(posedge clk) begin
    if (alu_value2 != 64'd0) begin
      case (alu_opcode)
        8'd0: alu_result <= alu_value1 + alu_value2;
        8'd1: alu_result <= alu_value1 - alu_value2;
        8'd2: alu_result <= alu_value1 * alu_value2;
        8'd3: alu_result <= $signed(alu_value1) / $signed(alu_value2);
        8'd4: alu_result <= alu_value1 ^ alu_value2;
        8'd5: alu_result <= alu_value1 & alu_value2;
        8'd6: alu_result <= alu_value1 | alu_value2;
        8'd7: alu_result <= $signed(alu_value1) % $signed(alu_value2);
        8'd8: alu_result <= ~alu_value1;
        default: alu_result <= 64'd0;
      endcase
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [4:0] idx, input logic [63:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one op and check every phase through the return of req_ready
  task automatic run_op(input string tag, input logic [7:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic use_imm,
                        input logic [11:0] imm, input logic [63:0] exp_val,
                        input logic exp_we, input logic exp_err);
    @(negedge clk);
    check_eq({tag, "_ready_idle"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    req_use_imm = use_imm; req_imm = imm;
    @(negedge clk);                      // READ
    req_valid = 1'b0;
    check_eq({tag, "_ready_read"}, {63'd0, req_ready}, 64'd0);
    check_eq({tag, "_rf_rs1"}, {59'd0, rf_rs1}, {59'd0, rs1});
    @(negedge clk);                      // EXEC
    check_eq({tag, "_alu_op"}, {56'd0, alu_opcode}, {56'd0, op});
    check_eq({tag, "_done_early"}, {63'd0, done_valid}, 64'd0);
    @(negedge clk);                      // WB
    check_eq({tag, "_done_valid"}, {63'd0, done_valid}, 64'd1);
    check_eq({tag, "_done_rd"}, {59'd0, done_rd}, {59'd0, rd});
    check_eq({tag, "_done_value"}, done_value, exp_err ? 64'd0 : exp_val);
    check_eq({tag, "_we"}, {63'd0, rf_write_sig}, {63'd0, exp_we});
    if (exp_we) begin
      check_eq({tag, "_wr_reg"}, {59'd0, rf_write_reg}, {59'd0, rd});
      check_eq({tag, "_wr_val"}, rf_write_val, exp_val);
    end
`ifdef EXEC_DIV0_TRAP_EN
    check_eq({tag, "_err"}, {63'd0, done_error}, {63'd0, exp_err});
`endif
    @(negedge clk);                      // back in IDLE
    check_eq({tag, "_done_pulse"}, {63'd0, done_valid}, 64'd0);
    check_eq({tag, "_ready_back"}, {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 8'd0; req_rs1 = 5'd0; req_rs2 = 5'd0;
    req_rd = 5'd0; req_use_imm = 1'b0; req_imm = 12'd0; rf_clr = 1'b1;
    repeat (3) @(negedge clk);
    rf_clr = 1'b0;
    check_eq("rst_ready", {63'd0, req_ready}, 64'd1);
    check_eq("rst_we", {63'd0, rf_write_sig}, 64'd0);
    check_eq("rst_done", {63'd0, done_valid}, 64'd0);
    check_eq("rst_alu_op", {56'd0, alu_opcode}, 64'd0);
    check_eq("rst_alu_v2", alu_value2, 64'd0);
    check_eq("rst_rf_rs1", {59'd0, rf_rs1}, 64'd0);
    check_eq("rst_done_err", {63'd0, done_error}, 64'd0);
    reset = 1'b0;

    preload(5'd1, 64'd5);
    preload(5'd2, 64'd7);
    run_op("add", OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 12'd0, 64'd12, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("add_rf_x3", regs[3], 64'd12);
    run_op("addi", OP_ADD, 5'd1, 5'd0, 5'd4, 1'b1, 12'hFFF, 64'd4, 1'b1, 1'b0);
    preload(5'd1, 64'd9);
    run_op("add_x0", OP_ADD, 5'd1, 5'd0, 5'd5, 1'b0, 12'd0, 64'd9, 1'b1, 1'b0);
`ifdef EXEC_DIV0_TRAP_EN
    run_op("div0", OP_DIV, 5'd1, 5'd0, 5'd6, 1'b0, 12'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    run_op("rem0", OP_REM, 5'd1, 5'd0, 5'd6, 1'b0, 12'd0, 64'd9, 1'b0, 1'b1);
`else
    run_op("div0", OP_DIV, 5'd1, 5'd0, 5'd6, 1'b0, 12'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    run_op("rem0", OP_REM, 5'd1, 5'd0, 5'd6, 1'b0, 12'd0, 64'd9, 1'b1, 1'b0);
`endif
    run_op("and_x0", OP_AND, 5'd1, 5'd0, 5'd7, 1'b0, 12'd0, 64'd0, 1'b1, 1'b0);
    run_op("not_x0", OP_NOT, 5'd1, 5'd0, 5'd8, 1'b0, 12'd0, ~64'd9, 1'b1, 1'b0);
    run_op("sub", OP_SUB, 5'd2, 5'd1, 5'd9, 1'b0, 12'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
    run_op("xor_rd0", OP_XOR, 5'd1, 5'd2, 5'd0, 1'b0, 12'd0, 64'd14, 1'b0, 1'b0);
    run_op("unknown", 8'd9, 5'd1, 5'd2, 5'd10, 1'b0, 12'd0, 64'd0, 1'b0, 1'b0);

    // Reset asserted in EXEC aborts the op
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADD; req_rs1 = 5'd1; req_rs2 = 5'd2; req_rd = 5'd11;
    req_use_imm = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_exec_we", {63'd0, rf_write_sig}, 64'd0);
    check_eq("rst_exec_done", {63'd0, done_valid}, 64'd0);
    check_eq("rst_exec_ready", {63'd0, req_ready}, 64'd1);
    repeat (2) @(negedge clk);
    check_eq("rst_exec_nowrite", regs[11], 64'd0);

    // req_valid held through a busy op is only taken again at N+4
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_ADD; req_rs1 = 5'd1; req_rs2 = 5'd2; req_rd = 5'd12;
    @(negedge clk);
    req_rd = 5'd13;
    check_eq("hold_ready_n1", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    check_eq("hold_ready_n2", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    check_eq("hold_rd_n3", {59'd0, done_rd}, 64'd12);
    check_eq("hold_ready_n3", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    check_eq("hold_ready_n4", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("hold2_ready", {63'd0, req_ready}, 64'd0);
    repeat (2) @(negedge clk);
    check_eq("hold2_done", {63'd0, done_valid}, 64'd1);
    check_eq("hold2_rd", {59'd0, done_rd}, 64'd13);
    check_eq("hold2_val", done_value, 64'd16);
    repeat (2) @(negedge clk);
    check_eq("hold_x12", regs[12], 64'd16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
